// File: rtl/hit_led_pkg.sv
// rtl/hit_led_pkg.sv - shared types, defaults and helpers for the hit LED driver
package hit_led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    FADE = 2'd2
  } ch_state_e;

  localparam int unsigned DEF_HOLD_CYCLES = 10_000_000;
  localparam int unsigned DEF_FADE_CYCLES = 1_000_000;
  localparam int unsigned DEF_PWM_BITS    = 4;

  // First fade level: one step below full brightness so the fade is visible
  function automatic int unsigned fade_start_level(input int unsigned pwm_bits);
    return (32'd1 << pwm_bits) - 32'd2;
  endfunction

endpackage

// File: rtl/hit_led_channel.sv
// rtl/hit_led_channel.sv - one track: hold then PWM fade-out, retriggerable
module hit_led_channel
  import hit_led_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned FADE_CYCLES = DEF_FADE_CYCLES,
  parameter int unsigned PWM_BITS    = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                trig,
  input  logic [PWM_BITS-1:0] pwm_next,
  output logic                led,
  output logic                busy
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int FW = (FADE_CYCLES > 1) ? $clog2(FADE_CYCLES) : 1;
  localparam logic [HW-1:0]       HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
  localparam logic [FW-1:0]       FADE_LOAD  = FW'(FADE_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] DUTY_START = PWM_BITS'(fade_start_level(PWM_BITS));

  ch_state_e           state, state_n;
  logic [HW-1:0]       hcnt, hcnt_n;
  logic [FW-1:0]       fcnt, fcnt_n;
  logic [PWM_BITS-1:0] duty, duty_n;
  logic                led_n, busy_n;

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hcnt  <= '0;
      fcnt  <= '0;
      duty  <= '0;
      led   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      hcnt  <= hcnt_n;
      fcnt  <= fcnt_n;
      duty  <= duty_n;
      led   <= led_n;
      busy  <= busy_n;
    end
  end

  // Next state; a trigger wins over any expiry in the same cycle.
  // LED is derived from next-state values so it lines up with pwm_cnt.
  always_comb begin
    state_n = state;
    hcnt_n  = hcnt;
    fcnt_n  = fcnt;
    duty_n  = duty;
    if (trig) begin
      state_n = HOLD;
      hcnt_n  = HOLD_LOAD;
    end else begin
      case (state)
        HOLD: begin
          if (hcnt == '0) begin
            state_n = FADE;
            duty_n  = DUTY_START;
            fcnt_n  = FADE_LOAD;
          end else begin
            hcnt_n = hcnt - 1'b1;
          end
        end
        FADE: begin
          if (fcnt == '0) begin
            if (duty == PWM_BITS'(1)) begin
              state_n = IDLE;
              duty_n  = '0;
            end else begin
              duty_n = duty - 1'b1;
              fcnt_n = FADE_LOAD;
            end
          end else begin
            fcnt_n = fcnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
    busy_n = (state_n != IDLE);
    led_n  = (state_n == HOLD) || ((state_n == FADE) && (pwm_next < duty_n));
  end

endmodule

// File: rtl/hit_led_driver.sv
// rtl/hit_led_driver.sv - N-track hit LED driver with a shared PWM counter
module hit_led_driver
  import hit_led_pkg::*;
#(
  parameter int unsigned N_TRACK     = 6,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned PWM_BITS    = DEF_PWM_BITS,
  parameter int unsigned FADE_CYCLES = DEF_FADE_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [N_TRACK-1:0] hit,
  output logic [N_TRACK-1:0] led,
  output logic [N_TRACK-1:0] busy
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] pwm_next;

  assign pwm_next = pwm_cnt + 1'b1;

  // Free-running PWM counter shared by all channels; wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_next;
  end

  for (genvar i = 0; i < N_TRACK; i++) begin : g_ch
    hit_led_channel #(
      .HOLD_CYCLES(HOLD_CYCLES),
      .FADE_CYCLES(FADE_CYCLES),
      .PWM_BITS   (PWM_BITS)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .trig    (hit[i] & enable),
      .pwm_next(pwm_next),
      .led     (led[i]),
      .busy    (busy[i])
    );
  end

endmodule

// File: tb/tb_hit_led_driver.sv
// tb/tb_hit_led_driver.sv - directed self-checking bench for hit_led_driver
module tb_hit_led_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [5:0] hit = '0;
  logic [5:0] led, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int ecnt     = 0;

  always #5 clk = ~clk;

  hit_led_driver #(
    .N_TRACK    (6),
    .HOLD_CYCLES(8),
    .PWM_BITS   (2),
    .FADE_CYCLES(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable),
    .hit   (hit),
    .led   (led),
    .busy  (busy)
  );

  // Expected busy as seen at edge k for a flash whose latest hit was sampled at edge t
  function automatic bit exp_busy(input int k, input int t);
    return (t > 0) && (k > t) && (k <= t + 16);
  endfunction

  // Hold 8 cycles, then duty 2 for 4 cycles, duty 1 for 4 cycles; pwm at edge k is (k-1)%4
  function automatic bit exp_led(input int k, input int t);
    int d;
    if (t <= 0) return 1'b0;
    d = k - t;
    if (d < 1)   return 1'b0;
    if (d <= 8)  return 1'b1;
    if (d <= 12) return ((k - 1) % 4) < 2;
    if (d <= 16) return ((k - 1) % 4) < 1;
    return 1'b0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic reset_dut();
    hit    = '0;
    enable = 1'b1;
    rst_n  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ecnt  = 0;
  endtask

  task automatic test_reset();
    hit   = '0;
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (led !== 6'b0) begin n_fail++; $display("FAIL reset_led got=%b exp=%b", led, 6'b0); end
    n_checks++;
    if (busy !== 6'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=%b", busy, 6'b0); end
    reset_dut();
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) step();
      n_checks++;
      if (led !== 6'b0 || busy !== 6'b0) begin
        n_fail++; $display("FAIL post_reset k=%0d led=%b busy=%b exp=0", k, led, busy);
      end
    end
  endtask

  task automatic test_single(input int t_extra, input string name);
    int last_t = 0;
    logic [5:0] el, eb;
    reset_dut();
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) step();
      el = {5'b0, exp_led(k, last_t)};
      eb = {5'b0, exp_busy(k, last_t)};
      n_checks++;
      if (led !== el) begin n_fail++; $display("FAIL %s_led k=%0d got=%b exp=%b", name, k, led, el); end
      n_checks++;
      if (busy !== eb) begin n_fail++; $display("FAIL %s_busy k=%0d got=%b exp=%b", name, k, busy, eb); end
      hit = (k == 10 || k == t_extra) ? 6'b000001 : 6'b0;
      if (hit[0]) last_t = k;
    end
    hit = '0;
  endtask

  task automatic test_retrigger(input int t2);
    int last_t = 0;
    logic [5:0] el, eb;
    reset_dut();
    for (int k = 1; k <= 45; k++) begin
      if (k > 1) step();
      el = {3'b0, exp_led(k, last_t), 2'b0};
      eb = {3'b0, exp_busy(k, last_t), 2'b0};
      n_checks++;
      if (led !== el) begin n_fail++; $display("FAIL retrig%0d_led k=%0d got=%b exp=%b", t2, k, led, el); end
      n_checks++;
      if (busy !== eb) begin n_fail++; $display("FAIL retrig%0d_busy k=%0d got=%b exp=%b", t2, k, busy, eb); end
      hit = (k == 10 || k == t2) ? 6'b000100 : 6'b0;
      if (hit[2]) last_t = k;
    end
    hit = '0;
  endtask

  task automatic test_simultaneous();
    int last_t = 0;
    logic [5:0] el, eb;
    reset_dut();
    for (int k = 1; k <= 32; k++) begin
      if (k > 1) step();
      el = {6{exp_led(k, last_t)}};
      eb = {6{exp_busy(k, last_t)}};
      n_checks++;
      if (led !== el) begin n_fail++; $display("FAIL simul_led k=%0d got=%b exp=%b", k, led, el); end
      n_checks++;
      if (busy !== eb) begin n_fail++; $display("FAIL simul_busy k=%0d got=%b exp=%b", k, busy, eb); end
      hit = (k == 10) ? 6'b111111 : 6'b0;
      if (k == 10) last_t = k;
    end
    hit = '0;
  endtask

  task automatic test_enable();
    int last_t = 0;
    logic [5:0] el, eb;
    reset_dut();
    enable = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) step();
      n_checks++;
      if (led !== 6'b0 || busy !== 6'b0) begin
        n_fail++; $display("FAIL gated k=%0d led=%b busy=%b exp=0", k, led, busy);
      end
      hit = (k == 10) ? 6'b000010 : 6'b0;
    end
    hit = '0;
    reset_dut();
    for (int k = 1; k <= 32; k++) begin
      if (k > 1) step();
      el = {4'b0, exp_led(k, last_t), 1'b0};
      eb = {4'b0, exp_busy(k, last_t), 1'b0};
      n_checks++;
      if (led !== el) begin n_fail++; $display("FAIL en_drop_led k=%0d got=%b exp=%b", k, led, el); end
      n_checks++;
      if (busy !== eb) begin n_fail++; $display("FAIL en_drop_busy k=%0d got=%b exp=%b", k, busy, eb); end
      enable = (k < 14);
      hit    = (k == 10 || k == 16) ? 6'b000010 : 6'b0;
      if (hit[1] && enable) last_t = k;
    end
    hit    = '0;
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_flash();
    int last_t = 0;
    logic [5:0] el, eb;
    reset_dut();
    for (int k = 1; k <= 13; k++) begin
      if (k > 1) step();
      hit = (k == 10) ? 6'b001000 : 6'b0;
    end
    hit = '0;
    step();
    n_checks++;
    if (busy !== 6'b001000) begin n_fail++; $display("FAIL pre_async busy got=%b exp=%b", busy, 6'b001000); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (led !== 6'b0) begin n_fail++; $display("FAIL async_led got=%b exp=%b", led, 6'b0); end
    n_checks++;
    if (busy !== 6'b0) begin n_fail++; $display("FAIL async_busy got=%b exp=%b", busy, 6'b0); end
    reset_dut();
    for (int k = 1; k <= 26; k++) begin
      if (k > 1) step();
      el = {1'b0, exp_led(k, last_t), 4'b0};
      eb = {1'b0, exp_busy(k, last_t), 4'b0};
      n_checks++;
      if (led !== el) begin n_fail++; $display("FAIL after_rst_led k=%0d got=%b exp=%b", k, led, el); end
      n_checks++;
      if (busy !== eb) begin n_fail++; $display("FAIL after_rst_busy k=%0d got=%b exp=%b", k, busy, eb); end
      hit = (k == 5) ? 6'b010000 : 6'b0;
      if (k == 5) last_t = k;
    end
    hit = '0;
  endtask

  initial begin
    test_reset();
    test_single(0, "single");
    test_retrigger(15);
    test_retrigger(20);
    test_simultaneous();
    test_enable();
    test_reset_mid_flash();
    test_single(26, "last_cycle");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
